// File: rtl/pe_status_cfg_writer_pkg.sv
// Shared constants, widths and state encoding for the PE status-register configuration writer.
package pe_status_cfg_writer_pkg;

    localparam int LAYER_W     = 3;
    localparam int ACT_W       = 6;
    localparam int ACT_NUM     = 8;
    localparam int STAT_ADDR_W = 16;
    localparam int STAT_DATA_W = 16;

    localparam logic [STAT_ADDR_W-1:0] ADDR_LAYER = 16'd0;
    localparam logic [STAT_ADDR_W-1:0] ADDR_ACT01 = 16'd2;
    localparam logic [STAT_ADDR_W-1:0] ADDR_ACT23 = 16'd4;
    localparam logic [STAT_ADDR_W-1:0] ADDR_ACT45 = 16'd6;
    localparam logic [STAT_ADDR_W-1:0] ADDR_ACT67 = 16'd8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAYER,
        ST_ACT,
        ST_DONE
    } state_t;

    function automatic logic [STAT_ADDR_W-1:0] act_pair_addr(input logic [1:0] k);
        case (k)
            2'd0:    return ADDR_ACT01;
            2'd1:    return ADDR_ACT23;
            2'd2:    return ADDR_ACT45;
            default: return ADDR_ACT67;
        endcase
    endfunction

    // Pair k packs act_no[2k] in the low byte and act_no[2k+1] in the high byte.
    function automatic logic [STAT_DATA_W-1:0] act_pair_data(input logic [ACT_NUM*ACT_W-1:0] act,
                                                             input logic [1:0] k);
        int idx;
        logic [ACT_W-1:0] lo;
        logic [ACT_W-1:0] hi;
        idx = 2 * ACT_W * int'(k);
        lo  = act[idx +: ACT_W];
        hi  = act[idx + ACT_W +: ACT_W];
        return {2'b00, hi, 2'b00, lo};
    endfunction

endpackage

// File: rtl/pe_status_cfg_writer_prio.sv
// Lowest-set-bit priority encoder: one-hot of the lowest selected PE plus a valid flag.
module pe_mask_prio_enc #(
    parameter int PE_NUM = 4
) (
    input  logic [PE_NUM-1:0] mask,
    output logic [PE_NUM-1:0] onehot,
    output logic              valid
);

    // Two's-complement trick isolates the lowest set bit.
    assign onehot = mask & ((~mask) + {{(PE_NUM-1){1'b0}}, 1'b1});
    assign valid  = |mask;

endmodule

// File: rtl/pe_status_cfg_writer.sv
// Captures one network descriptor and replays it as status-register writes to each selected PE.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | ready for a descriptor; no writes
// ST_LAYER | writing layer_no to address 0 of the current PE
// ST_ACT   | writing act_no pair k to address 2k+2 of the current PE
// ST_DONE  | one-cycle completion pulse, then back to idle
module pe_status_cfg_writer
    import pe_status_cfg_writer_pkg::*;
#(
    parameter int PE_NUM = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [LAYER_W-1:0]       cfg_layer_no,
    input  logic [ACT_NUM*ACT_W-1:0] cfg_act_no,
    input  logic [PE_NUM-1:0]        cfg_pe_mask,
    output logic [PE_NUM-1:0]        write_en,
    output logic [STAT_ADDR_W-1:0]   write_addr,
    output logic [STAT_DATA_W-1:0]   write_data,
    output logic                     busy,
    output logic                     done
);

    state_t                   state;
    logic [LAYER_W-1:0]       layer_no_q;
    logic [ACT_NUM*ACT_W-1:0] act_no_q;
    logic [PE_NUM-1:0]        rem_mask;
    logic [1:0]               pair_k;

    logic [PE_NUM-1:0]        enc_in;
    logic [PE_NUM-1:0]        enc_onehot;
    logic                     enc_valid;
    logic                     last_pair;

    // In idle the encoder looks ahead at the incoming mask so the first write
    // lands in the cycle right after the handshake; otherwise it picks the
    // next PE after the current one (held in write_en) is retired.
    assign enc_in    = (state == ST_IDLE) ? cfg_pe_mask : (rem_mask & ~write_en);
    assign last_pair = (pair_k == layer_no_q[2:1]);
    assign cfg_ready = (state == ST_IDLE);

    pe_mask_prio_enc #(.PE_NUM(PE_NUM)) u_prio_enc (
        .mask   (enc_in),
        .onehot (enc_onehot),
        .valid  (enc_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            layer_no_q <= '0;
            act_no_q   <= '0;
            rem_mask   <= '0;
            pair_k     <= '0;
            write_en   <= '0;
            write_addr <= '0;
            write_data <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        layer_no_q <= cfg_layer_no;
                        act_no_q   <= cfg_act_no;
                        rem_mask   <= cfg_pe_mask;
                        pair_k     <= '0;
                        busy       <= 1'b1;
                        if (enc_valid) begin
                            state      <= ST_LAYER;
                            write_en   <= enc_onehot;
                            write_addr <= ADDR_LAYER;
                            write_data <= {{(STAT_DATA_W-LAYER_W){1'b0}}, cfg_layer_no};
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_LAYER: begin
                    state      <= ST_ACT;
                    pair_k     <= '0;
                    write_addr <= act_pair_addr(2'd0);
                    write_data <= act_pair_data(act_no_q, 2'd0);
                end
                ST_ACT: begin
                    if (!last_pair) begin
                        pair_k     <= pair_k + 2'd1;
                        write_addr <= act_pair_addr(pair_k + 2'd1);
                        write_data <= act_pair_data(act_no_q, pair_k + 2'd1);
                    end else begin
                        rem_mask <= rem_mask & ~write_en;
                        pair_k   <= '0;
                        if (enc_valid) begin
                            state      <= ST_LAYER;
                            write_en   <= enc_onehot;
                            write_addr <= ADDR_LAYER;
                            write_data <= {{(STAT_DATA_W-LAYER_W){1'b0}}, layer_no_q};
                        end else begin
                            state      <= ST_DONE;
                            write_en   <= '0;
                            write_addr <= '0;
                            write_data <= '0;
                            done       <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_status_cfg_writer.sv
// Directed vector bench for pe_status_cfg_writer: write sequence, latency and handshake checks.
module tb_pe_status_cfg_writer;

    localparam int PE_NUM = 4;

    logic         clk;
    logic         rst_n;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [2:0]   cfg_layer_no;
    logic [47:0]  cfg_act_no;
    logic [PE_NUM-1:0] cfg_pe_mask;
    logic [PE_NUM-1:0] write_en;
    logic [15:0]  write_addr;
    logic [15:0]  write_data;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [2:0]  layer_no;
        logic [47:0] act_no;
        logic [3:0]  mask;
        int          exp_nwr;
        int          exp_lat;
        logic [15:0] exp_last;
    } vec_t;

    typedef struct {
        int          pe;
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    vec_t vecs[6];
    wr_t  expq[$];

    pe_status_cfg_writer #(.PE_NUM(PE_NUM)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_layer_no (cfg_layer_no),
        .cfg_act_no   (cfg_act_no),
        .cfg_pe_mask  (cfg_pe_mask),
        .write_en     (write_en),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference write list straight from the register map.
    task automatic build_expected(input vec_t v);
        wr_t e;
        logic [5:0] lo;
        logic [5:0] hi;
        expq.delete();
        for (int p = 0; p < PE_NUM; p++) begin
            if (v.mask[p]) begin
                e.pe = p; e.addr = 16'd0; e.data = {13'd0, v.layer_no};
                expq.push_back(e);
                for (int k = 0; k <= int'(v.layer_no) / 2; k++) begin
                    lo = v.act_no[12*k +: 6];
                    hi = v.act_no[12*k+6 +: 6];
                    e.pe = p; e.addr = 16'(2*k + 2); e.data = {2'b00, hi, 2'b00, lo};
                    expq.push_back(e);
                end
            end
        end
    endtask

    task automatic run_seq(input vec_t v, input bit hold, input string tag);
        int c;
        int nwr;
        bit got_done;
        logic [15:0] last_data;
        logic [3:0]  oh;
        logic [31:0] r0;
        logic [31:0] r1;
        wr_t e;
        build_expected(v);
        c = 0; nwr = 0; got_done = 0; last_data = '0;
        @(negedge clk);
        chk({tag, "_ready_idle"}, 64'(cfg_ready), 64'd1);
        cfg_layer_no = v.layer_no;
        cfg_act_no   = v.act_no;
        cfg_pe_mask  = v.mask;
        cfg_valid    = 1'b1;
        @(posedge clk);
        while (!got_done && c < 40) begin
            @(negedge clk);
            c++;
            chk({tag, "_ready_busy"}, 64'(cfg_ready), 64'd0);
            if (write_en != '0) begin
                if (expq.size() == 0) begin
                    chk({tag, "_extra_write"}, 64'(write_addr), 64'hFFFF);
                end else begin
                    e  = expq.pop_front();
                    oh = 4'(1 << e.pe);
                    chk({tag, "_wen"},   64'(write_en),   64'(oh));
                    chk({tag, "_waddr"}, 64'(write_addr), 64'(e.addr));
                    chk({tag, "_wdata"}, 64'(write_data), 64'(e.data));
                end
                nwr++;
                last_data = write_data;
            end
            if (done) begin
                got_done = 1;
                chk({tag, "_busy_at_done"}, 64'(busy), 64'd1);
            end
            if (hold) begin
                r0 = $urandom; r1 = $urandom;
                cfg_layer_no = r0[2:0];
                cfg_pe_mask  = r0[7:4];
                cfg_act_no   = {r0[31:16], r1};
            end else begin
                cfg_valid = 1'b0;
            end
        end
        cfg_valid = 1'b0;
        chk({tag, "_done_seen"}, 64'(got_done), 64'd1);
        chk({tag, "_done_lat"}, 64'(c), 64'(v.exp_lat));
        chk({tag, "_nwrites"}, 64'(nwr), 64'(v.exp_nwr));
        chk({tag, "_missing"}, 64'(expq.size()), 64'd0);
        if (v.exp_nwr != 0) chk({tag, "_last_data"}, 64'(last_data), 64'(v.exp_last));
        @(negedge clk);
        chk({tag, "_ready_after"}, 64'(cfg_ready), 64'd1);
        chk({tag, "_busy_after"},  64'(busy), 64'd0);
        chk({tag, "_done_after"},  64'(done), 64'd0);
        chk({tag, "_wen_after"},   64'(write_en), 64'd0);
    endtask

    initial begin
        vecs[0] = '{3'd3, {6'd0,6'd0,6'd0,6'd0,6'd10,6'd36,6'd44,6'd16}, 4'b0001, 3, 4, 16'h0A24};
        vecs[1] = '{3'd0, {6'd0,6'd0,6'd0,6'd0,6'd0,6'd0,6'd9,6'd5},     4'b1010, 4, 5, 16'h0905};
        vecs[2] = '{3'd7, {6'd8,6'd7,6'd6,6'd5,6'd4,6'd3,6'd2,6'd1},     4'b1111, 20, 21, 16'h0807};
        vecs[3] = '{3'd5, {6'd1,6'd2,6'd3,6'd4,6'd5,6'd6,6'd7,6'd8},     4'b0000, 0, 1, 16'h0000};
        vecs[4] = '{3'd2, {6'd0,6'd0,6'd0,6'd0,6'd2,6'd1,6'd0,6'd63},    4'b0100, 3, 4, 16'h0201};
        vecs[5] = '{3'd6, {8{6'h2A}},                                     4'b1001, 10, 11, 16'h2A2A};

        rst_n = 1'b0;
        cfg_valid = 1'b0;
        cfg_layer_no = '0;
        cfg_act_no = '0;
        cfg_pe_mask = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(cfg_ready), 64'd1);
        chk("rst_wen",   64'(write_en), 64'd0);
        chk("rst_addr",  64'(write_addr), 64'd0);
        chk("rst_data",  64'(write_data), 64'd0);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_done",  64'(done), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_seq(vecs[i], 1'b0, $sformatf("vec%0d", i));

        // Valid held high with churning inputs: only the first descriptor counts.
        run_seq(vecs[0], 1'b1, "hold");

        // Reset in the middle of ACT abandons the sequence.
        @(negedge clk);
        cfg_layer_no = vecs[2].layer_no;
        cfg_act_no   = vecs[2].act_no;
        cfg_pe_mask  = vecs[2].mask;
        cfg_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_wen_active", 64'(write_en), 64'd1);
        chk("mid_addr", 64'(write_addr), 64'd4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wen",  64'(write_en), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_addr", 64'(write_addr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(cfg_ready), 64'd1);
        chk("post_rst_wen",   64'(write_en), 64'd0);
        run_seq(vecs[1], 1'b0, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
